lc3_mmio_ctrl: RTL and testbench
================================

Name: lc3_mmio_ctrl

Overview:
Parametrised memory/MMIO controller behind the datapath MAR/MDR.
- Owns MAR, MDR, a word-organised RAM, and the keyboard (KBSR/KBDR) and display (DSR/DDR) registers.
- Adds configurable memory wait states, a mio_en/ready handshake FSM, real keyboard/display handshakes with status bits, interrupt requests and an unmapped-address error flag.

Parameters:
DW, 16, data width; also MAR width.
MEM_AW, 10, RAM word-index width; RAM depth = 2**MEM_AW words.
MEM_WAIT, 2, extra BUSY cycles for a RAM access (0..15).
IO_BASE, 16'hFE00, KBSR address. KBDR = IO_BASE+2, DSR = IO_BASE+4, DDR = IO_BASE+6.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ld_mar  in  1  MAR <= bus_in
ld_mdr  in  1  MDR <= (mio_en ? rd_data : bus_in)
gate_mdr  in  1  drive mdr_out
mio_en  in  1  access request; r_w sampled at start
r_w  in  1  1 = write, 0 = read
bus_in  in  DW  datapath bus
mdr_out  out  DW  MDR value when gate_mdr=1, else 0
mdr_oe  out  1  equals gate_mdr, for the bus mux
ready  out  1  access complete
bus_err  out  1  one-cycle pulse when an access hits an unmapped address
kb_valid  in  1  one-cycle key strobe
kb_data  in  8  key code
disp_valid  out  1  display character pending
disp_data  out  8  character being displayed
disp_ack  in  1  display consumed the character
kb_irq  out  1  KBSR[15] & KBSR[14]
disp_irq  out  1  DSR[15] & DSR[14]

Behaviour:
- Reset, clk/rst_n as decided: reset rst_n, asynchronous, active-low; clock clk.
  - Reset values: MAR=0, MDR=0, KBSR=0, KBDR=0, DSR=16'h8000, DDR=0.
  - Outputs at reset: ready=0, bus_err=0, disp_valid=0, FSM=IDLE.
  - RAM contents are not reset.
- Address decode on MAR:
  - I/O hit: MAR matches one of the four I/O addresses.
  - RAM hit: MAR < 2**(MEM_AW+1); word index = MAR[MEM_AW:1]; MAR[0] is ignored.
  - Otherwise unmapped.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: when mio_en=1, capture r_w and decode.
    - RAM hit with MEM_WAIT>0: go to BUSY, counter=MEM_WAIT-1.
    - All other cases: go to DONE.
  - BUSY: counter decrements; go to DONE when it reaches 0.
  - DONE: ready=1. Stay in DONE while mio_en=1; go to IDLE when mio_en=0.
  - ready therefore rises 1 cycle after start for I/O, unmapped, or MEM_WAIT=0, and MEM_WAIT+1 cycles after start otherwise.
- Write commit: occurs on the clock edge that enters DONE, using the MDR value at that edge.
  - RAM: RAM[idx] <= MDR.
  - KBSR: only bit 14 is writable.
  - DSR: only bit 14 is writable.
  - DDR: DDR <= MDR, but only if DSR[15]=1; otherwise the write is dropped silently.
  - KBDR: read-only; writes are ignored.
- Read data: rd_data is registered on entry to DONE and held stable while in DONE.
  - Sources: RAM word, KBSR, KBDR, DSR, or DDR.
  - Unmapped address returns 0.
- Unmapped access: bus_err pulses 1 cycle on the DONE-entry edge; no state changes.
- Keyboard:
  - kb_valid while KBSR[15]=0: KBDR <= {8'h0, kb_data}, KBSR[15] <= 1.
  - kb_valid while KBSR[15]=1: key dropped, KBSR[13] (overrun, sticky) <= 1.
  - A completed read of KBDR clears KBSR[15] and KBSR[13].
  - If kb_valid coincides with that clear, the new key wins: KBDR updated, KBSR[15] stays 1, KBSR[13] cleared.
- Display:
  - An accepted DDR write clears DSR[15], sets disp_valid=1, and sets disp_data=MDR[7:0] on the next cycle.
  - On disp_ack while disp_valid=1: disp_valid <= 0, DSR[15] <= 1.
  - disp_ack while disp_valid=0 is ignored.
- ld_mar and ld_mdr are accepted in any FSM state. Changing MAR during BUSY/DONE does not affect the access in flight; address and r_w are latched at start.
- Reset mid-access aborts the access: no write commits, FSM returns to IDLE.

Test Plan:
- MEM_WAIT=2: MAR=16'h0010, MDR=16'hBEEF, write access; then read MAR=16'h0010 -> ready rises 3 cycles after mio_en; ld_mdr loads 16'hBEEF; mdr_out=16'hBEEF with gate_mdr=1.
- kb_valid with kb_data=8'h41, then read KBSR -> 16'h8000; read KBDR -> 16'h0041; following KBSR read -> 16'h0000; ready 1 cycle after each start.
- Two kb_valid strobes (8'h41, 8'h42) with no read -> KBDR=16'h0041, KBSR=16'hA000; same-cycle kb_valid with KBDR-read completion -> KBSR[15] remains 1.
- Write DDR=16'h0058 -> DSR=16'h0000, disp_valid=1, disp_data=8'h58. Second DDR write before ack -> dropped. disp_ack -> DSR=16'h8000. Write DSR=16'h4000 -> disp_irq=1.
- Read MAR=16'hC000 (unmapped) -> bus_err 1-cycle pulse, rd_data=0, RAM and all registers unchanged.
- rst_n low during BUSY of a write to 16'h0020 -> FSM IDLE, ready=0, DSR=16'h8000, RAM[16] not written.

Source files
------------

// File: rtl/lc3_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// lc3_mmio_ctrl
// Memory / memory-mapped I/O controller that sits behind the datapath MAR/MDR.
// It owns MAR, MDR, a word-organised RAM and the keyboard (KBSR/KBDR) and
// display (DSR/DDR) device registers. Accesses are started with mio_en and
// complete with ready; RAM accesses may take extra wait states.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ld_mar            MAR <= bus_in
//   ld_mdr            MDR <= (mio_en ? rd_data : bus_in)
//   gate_mdr          drive mdr_out with MDR (else 0); mirrored on mdr_oe
//   mio_en, r_w       access request and direction (1 = write), latched at start
//   bus_in            datapath bus
//   mdr_out, mdr_oe   MDR value onto the bus and its output-enable
//   ready             access complete (high while in DONE)
//   bus_err           one-cycle pulse when an access hits an unmapped address
//   kb_valid, kb_data keyboard key strobe and key code
//   disp_valid/data   display character pending and its code
//   disp_ack          display consumed the pending character
//   kb_irq, disp_irq  device interrupt requests (ready & interrupt-enable)
// -----------------------------------------------------------------------------
module lc3_mmio_ctrl #(
    parameter int             DW       = 16,
    parameter int             MEM_AW   = 10,
    parameter int             MEM_WAIT = 2,
    parameter logic [DW-1:0]  IO_BASE  = 16'hFE00
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_mar,
    input  logic          ld_mdr,
    input  logic          gate_mdr,
    input  logic          mio_en,
    input  logic          r_w,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] mdr_out,
    output logic          mdr_oe,
    output logic          ready,
    output logic          bus_err,
    input  logic          kb_valid,
    input  logic [7:0]    kb_data,
    output logic          disp_valid,
    output logic [7:0]    disp_data,
    input  logic          disp_ack,
    output logic          kb_irq,
    output logic          disp_irq
);

    localparam int            RAM_DEPTH = 2 ** MEM_AW;
    localparam int            RAM_SHIFT = MEM_AW + 1;
    localparam bit            HAS_WAIT  = (MEM_WAIT > 0);
    localparam logic [3:0]    WAIT_LOAD = 4'(MEM_WAIT - 1);
    localparam logic [DW-1:0] KBSR_ADDR = IO_BASE;
    localparam logic [DW-1:0] KBDR_ADDR = IO_BASE + DW'(2);
    localparam logic [DW-1:0] DSR_ADDR  = IO_BASE + DW'(4);
    localparam logic [DW-1:0] DDR_ADDR  = IO_BASE + DW'(6);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        TG_RAM  = 3'd0,
        TG_KBSR = 3'd1,
        TG_KBDR = 3'd2,
        TG_DSR  = 3'd3,
        TG_DDR  = 3'd4,
        TG_NONE = 3'd5
    } tgt_t;

    // Architectural registers
    logic [DW-1:0]     mar_r;
    logic [DW-1:0]     mdr_r;
    logic [DW-1:0]     rd_data_r;
    logic [DW-1:0]     mem [0:RAM_DEPTH-1];

    // Keyboard status bits: ready (KBSR[15]), irq enable (KBSR[14]), overrun (KBSR[13])
    logic              kb_rdy_r;
    logic              kb_ie_r;
    logic              kb_ovr_r;
    logic [DW-1:0]     kbdr_r;

    // Display status bits: ready (DSR[15]), irq enable (DSR[14])
    logic              dsr_rdy_r;
    logic              dsr_ie_r;
    logic [DW-1:0]     ddr_r;
    logic              disp_valid_r;

    // Access FSM and latched access descriptor
    state_t            state_r;
    state_t            state_nxt_s;
    logic [3:0]        cnt_r;
    tgt_t              acc_tgt_r;
    logic              acc_wr_r;
    logic [MEM_AW-1:0] acc_idx_r;
    logic              ready_r;
    logic              bus_err_r;

    // Decode / control signals
    tgt_t              dec_tgt_s;
    logic              ram_hit_s;
    logic              start_s;
    logic              go_busy_s;
    logic              commit_s;
    tgt_t              cur_tgt_s;
    logic              cur_wr_s;
    logic [MEM_AW-1:0] cur_idx_s;
    logic [DW-1:0]     rd_sel_s;
    logic [DW-1:0]     kbsr_s;
    logic [DW-1:0]     dsr_s;
    logic              ram_we_s;
    logic              kbdr_clr_s;
    logic              ddr_acc_s;

    assign kbsr_s = {kb_rdy_r, kb_ie_r, kb_ovr_r, {(DW-3){1'b0}}};
    assign dsr_s  = {dsr_rdy_r, dsr_ie_r, {(DW-2){1'b0}}};

    // Decode the current MAR into an access target; I/O addresses take priority
    always_comb begin
        ram_hit_s = ((mar_r >> RAM_SHIFT) == {DW{1'b0}});
        if (mar_r == KBSR_ADDR) begin
            dec_tgt_s = TG_KBSR;
        end else if (mar_r == KBDR_ADDR) begin
            dec_tgt_s = TG_KBDR;
        end else if (mar_r == DSR_ADDR) begin
            dec_tgt_s = TG_DSR;
        end else if (mar_r == DDR_ADDR) begin
            dec_tgt_s = TG_DDR;
        end else if (ram_hit_s) begin
            dec_tgt_s = TG_RAM;
        end else begin
            dec_tgt_s = TG_NONE;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mio_en) begin
                    if ((dec_tgt_s == TG_RAM) && HAS_WAIT) begin
                        state_nxt_s = ST_BUSY;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (mio_en) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: start/commit strobes and the descriptor of the access being committed.
    // A commit from IDLE uses the live decode; a commit from BUSY uses the latched one,
    // so MAR/r_w changes after the start never affect the access in flight.
    always_comb begin
        start_s   = 1'b0;
        go_busy_s = 1'b0;
        commit_s  = 1'b0;
        cur_tgt_s = acc_tgt_r;
        cur_wr_s  = acc_wr_r;
        cur_idx_s = acc_idx_r;
        case (state_r)
            ST_IDLE: begin
                start_s   = mio_en;
                go_busy_s = mio_en && (dec_tgt_s == TG_RAM) && HAS_WAIT;
                commit_s  = mio_en && !go_busy_s;
                cur_tgt_s = dec_tgt_s;
                cur_wr_s  = r_w;
                cur_idx_s = mar_r[MEM_AW:1];
            end
            ST_BUSY: begin
                commit_s = (cnt_r == 4'd0);
            end
            ST_DONE: begin
                commit_s = 1'b0;
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    // Latch access descriptor at start and run the wait-state counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_tgt_r <= TG_NONE;
            acc_wr_r  <= 1'b0;
            acc_idx_r <= {MEM_AW{1'b0}};
            cnt_r     <= 4'd0;
        end else begin
            if (start_s) begin
                acc_tgt_r <= dec_tgt_s;
                acc_wr_r  <= r_w;
                acc_idx_r <= mar_r[MEM_AW:1];
            end
            if (go_busy_s) begin
                cnt_r <= WAIT_LOAD;
            end else if ((state_r == ST_BUSY) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // ready and bus_err registered from the DONE-entry condition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r   <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            ready_r   <= (state_nxt_s == ST_DONE);
            bus_err_r <= commit_s && (cur_tgt_s == TG_NONE);
        end
    end

    // MAR / MDR load paths, accepted in any FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar_r <= {DW{1'b0}};
            mdr_r <= {DW{1'b0}};
        end else begin
            if (ld_mar) begin
                mar_r <= bus_in;
            end
            if (ld_mdr) begin
                mdr_r <= mio_en ? rd_data_r : bus_in;
            end
        end
    end

    // RAM write enable is gated by rst_n so an access can never commit under reset
    assign ram_we_s = rst_n && commit_s && cur_wr_s && (cur_tgt_s == TG_RAM);

    // RAM storage (not reset)
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem[cur_idx_s] <= mdr_r;
        end
    end

    // Read-data source select; unmapped reads return zero
    always_comb begin
        rd_sel_s = {DW{1'b0}};
        case (cur_tgt_s)
            TG_RAM:  rd_sel_s = mem[cur_idx_s];
            TG_KBSR: rd_sel_s = kbsr_s;
            TG_KBDR: rd_sel_s = kbdr_r;
            TG_DSR:  rd_sel_s = dsr_s;
            TG_DDR:  rd_sel_s = ddr_r;
            default: rd_sel_s = {DW{1'b0}};
        endcase
    end

    // Read data captured on DONE entry and held while in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {DW{1'b0}};
        end else if (commit_s && !cur_wr_s) begin
            rd_data_r <= rd_sel_s;
        end
    end

    assign kbdr_clr_s = commit_s && !cur_wr_s && (cur_tgt_s == TG_KBDR);

    // Keyboard registers: a key arriving with the KBDR-read clear wins over the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_rdy_r <= 1'b0;
            kb_ie_r  <= 1'b0;
            kb_ovr_r <= 1'b0;
            kbdr_r   <= {DW{1'b0}};
        end else begin
            if (kb_valid && (!kb_rdy_r || kbdr_clr_s)) begin
                kbdr_r   <= {{(DW-8){1'b0}}, kb_data};
                kb_rdy_r <= 1'b1;
                if (kbdr_clr_s) begin
                    kb_ovr_r <= 1'b0;
                end
            end else if (kb_valid) begin
                kb_ovr_r <= 1'b1;
            end else if (kbdr_clr_s) begin
                kb_rdy_r <= 1'b0;
                kb_ovr_r <= 1'b0;
            end
            if (commit_s && cur_wr_s && (cur_tgt_s == TG_KBSR)) begin
                kb_ie_r <= mdr_r[DW-2];
            end
        end
    end

    // A DDR write is only accepted while the display is ready
    assign ddr_acc_s = commit_s && cur_wr_s && (cur_tgt_s == TG_DDR) && dsr_rdy_r;

    // Display registers and character handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsr_rdy_r    <= 1'b1;
            dsr_ie_r     <= 1'b0;
            ddr_r        <= {DW{1'b0}};
            disp_valid_r <= 1'b0;
        end else begin
            if (ddr_acc_s) begin
                ddr_r        <= mdr_r;
                dsr_rdy_r    <= 1'b0;
                disp_valid_r <= 1'b1;
            end else if (disp_ack && disp_valid_r) begin
                disp_valid_r <= 1'b0;
                dsr_rdy_r    <= 1'b1;
            end
            if (commit_s && cur_wr_s && (cur_tgt_s == TG_DSR)) begin
                dsr_ie_r <= mdr_r[DW-2];
            end
        end
    end

    assign mdr_out    = gate_mdr ? mdr_r : {DW{1'b0}};
    assign mdr_oe     = gate_mdr;
    assign ready      = ready_r;
    assign bus_err    = bus_err_r;
    assign disp_valid = disp_valid_r;
    assign disp_data  = ddr_r[7:0];
    assign kb_irq     = kb_rdy_r & kb_ie_r;
    assign disp_irq   = dsr_rdy_r & dsr_ie_r;

endmodule

// File: tb/tb_lc3_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lc3_mmio_ctrl
// Directed bench for lc3_mmio_ctrl (DW=16, MEM_AW=10, MEM_WAIT=2).
// Expected read data and access latencies are queued when an access is
// driven and popped when the controller signals ready.
// -----------------------------------------------------------------------------
module tb_lc3_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_mar = 1'b0;
    logic        ld_mdr = 1'b0;
    logic        gate_mdr = 1'b0;
    logic        mio_en = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] bus_in = 16'h0000;
    logic [15:0] mdr_out;
    logic        mdr_oe;
    logic        ready;
    logic        bus_err;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = 8'h00;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ack = 1'b0;
    logic        kb_irq;
    logic        disp_irq;

    int          checks = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    int          lat_q[$];

    lc3_mmio_ctrl #(
        .DW       (16),
        .MEM_AW   (10),
        .MEM_WAIT (2),
        .IO_BASE  (16'hFE00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_mar     (ld_mar),
        .ld_mdr     (ld_mdr),
        .gate_mdr   (gate_mdr),
        .mio_en     (mio_en),
        .r_w        (r_w),
        .bus_in     (bus_in),
        .mdr_out    (mdr_out),
        .mdr_oe     (mdr_oe),
        .ready      (ready),
        .bus_err    (bus_err),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ack   (disp_ack),
        .kb_irq     (kb_irq),
        .disp_irq   (disp_irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access: load MAR (and MDR for writes), raise mio_en, wait for
    // ready, check latency/bus_err, and for reads load MDR from rd_data and gate it out.
    task automatic access(input string tag, input logic [15:0] addr, input logic wr,
                          input logic [15:0] data, input int exp_lat, input logic exp_err,
                          input logic kbv, input logic [7:0] kbd);
        int n;
        bus_in = addr;
        ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0;
        if (wr) begin
            bus_in = data;
            ld_mdr = 1'b1;
            tick();
            ld_mdr = 1'b0;
        end
        lat_q.push_back(exp_lat);
        mio_en   = 1'b1;
        r_w      = wr;
        kb_valid = kbv;
        kb_data  = kbd;
        n = 0;
        do begin
            tick();
            kb_valid = 1'b0;
            n++;
        end while (!ready && n < 20);
        chk({tag, "_lat"}, n, lat_q.pop_front());
        chk({tag, "_err"}, {31'd0, bus_err}, {31'd0, exp_err});
        if (!wr) begin
            ld_mdr = 1'b1;
            tick();
            ld_mdr   = 1'b0;
            gate_mdr = 1'b1;
            #1;
            chk({tag, "_rd"}, {16'd0, mdr_out}, {16'd0, exp_q.pop_front()});
            gate_mdr = 1'b0;
        end
        mio_en = 1'b0;
        tick();
        chk({tag, "_errclr"}, {31'd0, bus_err}, 32'd0);
        chk({tag, "_rdyclr"}, {31'd0, ready}, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp,
                      input int lat, input logic err);
        exp_q.push_back(exp);
        access(tag, addr, 1'b0, 16'h0000, lat, err, 1'b0, 8'h00);
    endtask

    task automatic wr(input string tag, input logic [15:0] addr, input logic [15:0] data,
                      input int lat, input logic err);
        access(tag, addr, 1'b1, data, lat, err, 1'b0, 8'h00);
    endtask

    task automatic key(input logic [7:0] code);
        kb_valid = 1'b1;
        kb_data  = code;
        tick();
        kb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick(); tick();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
        gate_mdr = 1'b1;
        #1;
        chk("rst_mdr", {16'd0, mdr_out}, 32'd0);
        chk("rst_oe", {31'd0, mdr_oe}, 32'd1);
        gate_mdr = 1'b0;
        #1;
        chk("oe_off", {31'd0, mdr_oe}, 32'd0);
        rst_n = 1'b1;
        tick();

        // RAM with two wait states, MAR[0] ignored
        wr("ram_wr", 16'h0010, 16'hBEEF, 3, 1'b0);
        rd("ram_rd", 16'h0010, 16'hBEEF, 3, 1'b0);
        rd("ram_rd_odd", 16'h0011, 16'hBEEF, 3, 1'b0);
        wr("ram_wr20", 16'h0020, 16'h2222, 3, 1'b0);
        rd("dsr_rst", 16'hFE04, 16'h8000, 1, 1'b0);

        // Keyboard single key
        key(8'h41);
        chk("kb_irq_off", {31'd0, kb_irq}, 32'd0);
        rd("kbsr_full", 16'hFE00, 16'h8000, 1, 1'b0);
        rd("kbdr_41", 16'hFE02, 16'h0041, 1, 1'b0);
        rd("kbsr_clr", 16'hFE00, 16'h0000, 1, 1'b0);

        // Overrun
        key(8'h41);
        key(8'h42);
        rd("kbsr_ovr", 16'hFE00, 16'hA000, 1, 1'b0);
        rd("kbdr_ovr", 16'hFE02, 16'h0041, 1, 1'b0);
        rd("kbsr_ovr_clr", 16'hFE00, 16'h0000, 1, 1'b0);

        // Key arriving together with the KBDR-read completion
        key(8'h43);
        key(8'h45);
        rd("kbsr_ovr2", 16'hFE00, 16'hA000, 1, 1'b0);
        exp_q.push_back(16'h0043);
        access("kbdr_race", 16'hFE02, 1'b0, 16'h0000, 1, 1'b0, 1'b1, 8'h44);
        rd("kbsr_race", 16'hFE00, 16'h8000, 1, 1'b0);
        rd("kbdr_44", 16'hFE02, 16'h0044, 1, 1'b0);
        rd("kbsr_clr2", 16'hFE00, 16'h0000, 1, 1'b0);

        // KBSR: only bit 14 writable, interrupt request
        wr("kbsr_wr", 16'hFE00, 16'hFFFF, 1, 1'b0);
        rd("kbsr_ie", 16'hFE00, 16'h4000, 1, 1'b0);
        chk("kb_irq_ie_only", {31'd0, kb_irq}, 32'd0);
        key(8'h46);
        chk("kb_irq_on", {31'd0, kb_irq}, 32'd1);
        wr("kbdr_wr_ign", 16'hFE02, 16'h1234, 1, 1'b0);
        rd("kbdr_46", 16'hFE02, 16'h0046, 1, 1'b0);
        chk("kb_irq_clr", {31'd0, kb_irq}, 32'd0);

        // Display
        wr("ddr_wr", 16'hFE06, 16'h0058, 1, 1'b0);
        chk("disp_valid_set", {31'd0, disp_valid}, 32'd1);
        chk("disp_data_58", {24'd0, disp_data}, 32'h58);
        rd("dsr_busy", 16'hFE04, 16'h0000, 1, 1'b0);
        wr("ddr_drop", 16'hFE06, 16'h0059, 1, 1'b0);
        rd("ddr_kept", 16'hFE06, 16'h0058, 1, 1'b0);
        chk("disp_data_kept", {24'd0, disp_data}, 32'h58);
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        chk("disp_valid_clr", {31'd0, disp_valid}, 32'd0);
        rd("dsr_ready", 16'hFE04, 16'h8000, 1, 1'b0);
        wr("dsr_wr", 16'hFE04, 16'h4000, 1, 1'b0);
        chk("disp_irq_on", {31'd0, disp_irq}, 32'd1);
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        rd("dsr_ack_ign", 16'hFE04, 16'hC000, 1, 1'b0);

        // Unmapped accesses
        rd("unm_rd", 16'hC000, 16'h0000, 1, 1'b1);
        wr("unm_wr", 16'hC000, 16'h1234, 1, 1'b1);
        rd("ram_after_unm", 16'h0010, 16'hBEEF, 3, 1'b0);
        rd("dsr_after_unm", 16'hFE04, 16'hC000, 1, 1'b0);
        rd("kbsr_after_unm", 16'hFE00, 16'h4000, 1, 1'b0);

        // Reset during BUSY of a RAM write
        bus_in = 16'h0020;
        ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0;
        bus_in = 16'h1111;
        ld_mdr = 1'b1;
        tick();
        ld_mdr = 1'b0;
        mio_en = 1'b1;
        r_w    = 1'b1;
        tick();
        chk("busy_not_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        chk("rst_mid_ready", {31'd0, ready}, 32'd0);
        chk("rst_mid_irq", {31'd0, disp_irq}, 32'd0);
        mio_en = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, ready}, 32'd0);
        rd("dsr_post_rst", 16'hFE04, 16'h8000, 1, 1'b0);
        rd("kbsr_post_rst", 16'hFE00, 16'h0000, 1, 1'b0);
        rd("ram20_kept", 16'h0020, 16'h2222, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
